trans_sched: RTL

Scheduler for the `trans_core` two-lane, 8x8 32-bit word transport.
- Arbitrates per-source word-transfer requests; grants up to two transfers per cycle, one per lane.
- Drives `isel`/`osel` with the one-cycle offset that the crossbar's pipeline register requires.
- Reports delivery to each destination.
- With lane 1 disabled, drives `trans_lsab`, whose lane 1 is the `lsab` bypass.

---
 rtl/trans_pkg.sv | 21 ++
 rtl/trans_rr_pick.sv | 34 +++
 rtl/trans_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/trans_pkg.sv
// Shared sizes, lane/mux bit offsets and the stage-B record for the
// two-lane 8x8 word-transport scheduler.
package trans_pkg;

  localparam int NPORT  = 8;
  localparam int NLANE  = 2;
  localparam int PIDX_W = 3;

  // Lane 1 selects live in isel[15:8]; out-mux lane flags in osel[15:8].
  localparam int ISEL_L1_OFS  = 8;
  localparam int OSEL_MUX_OFS = 8;

  typedef logic [PIDX_W-1:0] pidx_t;

  typedef struct packed {
    logic  vld;
    pidx_t dst;
    logic  lane;
  } stb_t;

endpackage

// File: rtl/trans_rr_pick.sv
// Rotating find-first: first set bit of (req & ~excl) scanning upward
// from start, modulo NPORT. Returns one-hot and index.
module trans_rr_pick
  import trans_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  pidx_t            start,
  input  logic [NPORT-1:0] excl,
  output logic [NPORT-1:0] gnt_oh,
  output pidx_t            idx,
  output logic             found
);

  logic [NPORT-1:0] cand;
  pidx_t            pos;

  assign cand = req & ~excl;

  always_comb begin
    found  = 1'b0;
    idx    = start;
    gnt_oh = '0;
    pos    = '0;
    for (int i = 0; i < NPORT; i++) begin
      pos = start + pidx_t'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    gnt_oh[idx] = found;
  end

endmodule

// File: rtl/trans_sched.sv
// Two-lane transfer scheduler for trans_core/trans_lsab: round-robin grant
// at the decision edge, crossbar out-select one edge later, delivery one more.
module trans_sched
  import trans_pkg::*;
#(
  parameter bit LANE1_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NPORT-1:0]     src_req,
  input  logic [NPORT*3-1:0]   src_dst,
  input  logic [NPORT-1:0]     dst_busy,
  output logic [NPORT-1:0]     src_gnt,
  output logic [2*NPORT-1:0]   isel,
  output logic [2*NPORT-1:0]   osel,
  output logic [NPORT-1:0]     dst_vld,
  output logic [15:0]          xfer_cnt
);

  logic [NPORT-1:0]   src_gnt_q, src_gnt_d;
  logic [2*NPORT-1:0] isel_q, isel_d;
  logic [2*NPORT-1:0] osel_q, osel_d;
  logic [NPORT-1:0]   dst_vld_q, dst_vld_d;
  logic [15:0]        xfer_cnt_q, xfer_cnt_d;
  pidx_t              rr_q, rr_d;
  stb_t [NLANE-1:0]   stb_q, stb_d;

  pidx_t            dst_s [NPORT];
  logic [NPORT-1:0] elig, excl1, gnt0, gnt1;
  pidx_t            idx0, idx1, dst0, dst1, rel0, start1;
  logic             found0, found1;

  assign dst0   = dst_s[idx0];
  assign dst1   = dst_s[idx1];
  assign rel0   = idx0 - rr_q;
  assign start1 = idx0 + 1'b1;

  // The previous grant masks a source: its old request is still visible.
  // Lane 1 may not reuse lane 0's source or destination, nor wrap back to rr.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_src
    pidx_t rel_s;
    assign rel_s     = pidx_t'(gi) - rr_q;
    assign dst_s[gi] = src_dst[PIDX_W*gi +: PIDX_W];
    assign elig[gi]  = src_req[gi] & ~dst_busy[dst_s[gi]] & ~src_gnt_q[gi];
    assign excl1[gi] = !LANE1_EN || !found0 || (rel_s <= rel0) || (dst_s[gi] == dst0);
  end

  trans_rr_pick u_pick0 (
    .req    (elig),
    .start  (rr_q),
    .excl   ({NPORT{1'b0}}),
    .gnt_oh (gnt0),
    .idx    (idx0),
    .found  (found0)
  );

  trans_rr_pick u_pick1 (
    .req    (elig),
    .start  (start1),
    .excl   (excl1),
    .gnt_oh (gnt1),
    .idx    (idx1),
    .found  (found1)
  );

  always_comb begin
    src_gnt_d = gnt0 | gnt1;
    isel_d    = '0;
    isel_d[0 +: NPORT]           = gnt0;
    isel_d[ISEL_L1_OFS +: NPORT] = gnt1;
    xfer_cnt_d = xfer_cnt_q + 16'(found0) + 16'(found1);

    rr_d = rr_q;
    if (found1)      rr_d = idx1 + 1'b1;
    else if (found0) rr_d = idx0 + 1'b1;

    stb_d[0] = '{vld: found0, dst: dst0, lane: 1'b0};
    stb_d[1] = '{vld: found1, dst: dst1, lane: 1'b1};

    osel_d = '0;
    for (int l = 0; l < NLANE; l++) begin
      if (stb_q[l].vld) begin
        osel_d[stb_q[l].dst]                     = 1'b1;
        osel_d[OSEL_MUX_OFS + int'(stb_q[l].dst)] = ~stb_q[l].lane;
      end
    end

    dst_vld_d = osel_q[NPORT-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      src_gnt_q  <= '0;
      isel_q     <= '0;
      osel_q     <= '0;
      dst_vld_q  <= '0;
      xfer_cnt_q <= '0;
      rr_q       <= '0;
      stb_q      <= '0;
    end else begin
      src_gnt_q  <= src_gnt_d;
      isel_q     <= isel_d;
      osel_q     <= osel_d;
      dst_vld_q  <= dst_vld_d;
      xfer_cnt_q <= xfer_cnt_d;
      rr_q       <= rr_d;
      stb_q      <= stb_d;
    end
  end

  assign src_gnt  = src_gnt_q;
  assign isel     = isel_q;
  assign osel     = osel_q;
  assign dst_vld  = dst_vld_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule
